// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access path: DMType encodings,
// access-unit state encoding and the illegal-access rule used at accept.
package dm_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } dm_state_t;

    // Encodings above DM_BYTE_U do not exist; unsigned variants only make
    // sense for loads, so a store that names one is rejected.
    function automatic logic dm_illegal(input logic we, input logic [2:0] dmtype);
        return (dmtype > DM_BYTE_U) ||
               (we && ((dmtype == DM_HALF_U) || (dmtype == DM_BYTE_U)));
    endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// Core request/response and memory bus signals of the data-memory access
// unit. The unit uses the slave view; the core/memory side uses master.
interface dm_access_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_dmtype;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_dmtype, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_dmtype, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/dm_access_unit_lane.sv
// Byte-lane formatting for one access: byte enables, store-data
// replication, load-lane extraction with extension, and alignment check.
module dm_lane
    import dm_pkg::*;
(
    input  logic [2:0]  dmtype,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [15:0] lane_h;
    logic [7:0]  lane_b;

    assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    assign lane_b = rdata[{addr_lo, 3'b000} +: 8];

    // Decode the access size into lane controls and the extended load value.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = 32'h0;
        misalign  = 1'b0;
        case (dmtype)
            DM_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
                misalign  = |addr_lo;
            end
            DM_HALF, DM_HALF_U: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = (dmtype == DM_HALF) ? {{16{lane_h[15]}}, lane_h}
                                                : {16'h0, lane_h};
                misalign  = addr_lo[0];
            end
            DM_BYTE, DM_BYTE_U: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = (dmtype == DM_BYTE) ? {{24{lane_b[7]}}, lane_b}
                                                : {24'h0, lane_b};
                misalign  = 1'b0;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
                rdata_ext = 32'h0;
                misalign  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access unit: turns one core load/store into one word access
// on a variable-latency memory bus, with a bounded wait and a one-cycle
// completion pulse. All outputs are registered.
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    dm_access_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    dm_state_t          state;
    dm_state_t          state_next;
    logic               lat_we;
    logic [2:0]         lat_dmtype;
    logic [1:0]         lat_addr_lo;
    logic [CNT_W-1:0]   cnt;

    logic [2:0]         lane_dmtype;
    logic [1:0]         lane_addr_lo;
    logic [3:0]         lane_be;
    logic [31:0]        lane_wdata;
    logic [31:0]        lane_rdata;
    logic               lane_misalign;

    logic               accept;
    logic               accept_err;
    logic               timed_out;

    // The lane formatter sees the live request while idle (to build the
    // memory fields) and the latched request afterwards (to format the load).
    assign lane_dmtype  = (state == ST_IDLE) ? bus.req_dmtype    : lat_dmtype;
    assign lane_addr_lo = (state == ST_IDLE) ? bus.req_addr[1:0] : lat_addr_lo;

    dm_lane u_lane (
        .dmtype    (lane_dmtype),
        .addr_lo   (lane_addr_lo),
        .wdata     (bus.req_wdata),
        .rdata     (bus.mem_rdata),
        .be        (lane_be),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata),
        .misalign  (lane_misalign)
    );

    assign accept     = bus.req_valid & bus.req_ready;
    assign accept_err = dm_illegal(bus.req_we, bus.req_dmtype) | lane_misalign;
    // The cycle that would take the counter to TIMEOUT is the last one waited.
    assign timed_out  = (cnt == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: errors found at accept skip the memory entirely; an ack
    // and a timeout in the same cycle both lead to RESP (ack wins in data).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = accept_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (bus.mem_ack || timed_out) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, request latches and the wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= 30'h0;
            bus.mem_be     <= 4'h0;
            bus.mem_wdata  <= 32'h0;
            lat_we         <= 1'b0;
            lat_dmtype     <= 3'h0;
            lat_addr_lo    <= 2'h0;
            cnt            <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_we        <= bus.req_we;
                        lat_dmtype    <= bus.req_dmtype;
                        lat_addr_lo   <= bus.req_addr[1:0];
                        bus.mem_addr  <= bus.req_addr[31:2];
                        bus.mem_be    <= lane_be;
                        bus.mem_wdata <= lane_wdata;
                        bus.req_ready <= 1'b0;
                        cnt           <= '0;
                        if (accept_err) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= 32'h0;
                        end else begin
                            bus.mem_req <= 1'b1;
                            bus.mem_we  <= bus.req_we;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (bus.mem_ack) begin
                        bus.mem_req    <= 1'b0;
                        bus.mem_we     <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= lat_we ? 32'h0 : lane_rdata;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (timed_out) begin
                            bus.mem_req    <= 1'b0;
                            bus.mem_we     <= 1'b0;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= 32'h0;
                        end
                    end
                end
                ST_RESP: begin
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= 32'h0;
                    bus.req_ready  <= 1'b1;
                end
                default: begin
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: a driver issues loads/stores, a memory responder
// acks after a chosen delay and checks the bus fields, and a monitor checks
// each completion pulse against a queue of expected responses.
module tb_dm_access_unit;

    localparam int TO = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          d;
    } mem_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mcnt = 0;
    bit   cur_valid = 0;
    mem_t cur;

    resp_t sb_q[$];
    mem_t  mq[$];

    dm_access_if bus ();

    dm_access_unit #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference rules: access size and offset give lanes; loads shift the
    // addressed lane down and extend; stores repeat the low bytes.
    function automatic void model(input logic we, input logic [2:0] dm,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata,
                                  output logic err, output logic [31:0] rext,
                                  output logic [3:0] be, output logic [31:0] wrep);
        int size;
        bit sgn;
        int off;
        logic [63:0] mask;
        logic [31:0] val;
        size = 0;
        sgn  = 0;
        case (dm)
            3'd0: size = 4;
            3'd1: begin size = 2; sgn = 1; end
            3'd2: size = 2;
            3'd3: begin size = 1; sgn = 1; end
            3'd4: size = 1;
            default: size = 0;
        endcase
        off = int'(addr[1:0]);
        if (size == 0) err = 1'b1;
        else err = (we && (dm == 3'd2 || dm == 3'd4)) || ((off % size) != 0);
        be = (size == 0) ? 4'b0 : 4'(((1 << size) - 1) << off);
        wrep = wdata;
        if (size != 0)
            for (int i = 0; i < 4; i++) wrep[8*i +: 8] = wdata[8*(i % size) +: 8];
        mask = (64'd1 << (8 * size)) - 64'd1;
        val  = (rdata >> (8 * off)) & mask[31:0];
        if (sgn) begin
            if (val[8*size-1]) val = val | ~mask[31:0];
        end
        rext = val;
    endfunction

    task automatic garbage();
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_dmtype = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            garbage();
        end
    endtask

    // Called just after a negedge; returns just after the negedge that
    // follows the accepting edge.
    task automatic issue(input logic we, input logic [2:0] dm, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int d,
                         input bit acc_err, input logic [31:0] exp_rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_wrep,
                         input bit push_resp);
        resp_t r;
        mem_t  m;
        bit    got;
        got = 0;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_dmtype = dm;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        for (int k = 0; k < 100; k++) begin
            if (bus.req_ready === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            flag("req_ready_wait_expired");
            garbage();
            return;
        end
        r.err   = acc_err || (d > TO);
        r.rdata = exp_rdata;
        if (acc_err)     r.cyc = cyc + 1;
        else if (d > TO) r.cyc = cyc + 1 + TO;
        else             r.cyc = cyc + 1 + d;
        if (push_resp) sb_q.push_back(r);
        if (!acc_err) begin
            m.we    = we;
            m.addr  = addr[31:2];
            m.be    = exp_be;
            m.wdata = exp_wrep;
            m.rdata = rdata;
            m.d     = d;
            mq.push_back(m);
        end
        @(negedge clk);
        garbage();
    endtask

    task automatic issue_rand();
        logic        we;
        logic [2:0]  dm;
        logic [31:0] addr, wdata, rdata, rext, wrep, exp_rdata;
        logic [3:0]  be;
        logic        err;
        int          d;
        we    = 1'($urandom);
        dm    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        addr  = $urandom;
        wdata = $urandom;
        rdata = $urandom;
        d     = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(1, TO);
        model(we, dm, addr, wdata, rdata, err, rext, be, wrep);
        exp_rdata = (err || we || d > TO) ? 32'h0 : rext;
        issue(we, dm, addr, wdata, rdata, d, err, exp_rdata, be, wrep, 1'b1);
    endtask

    // Completion monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        resp_t e;
        if (!rst && bus.resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                flag("unexpected_resp_valid");
            end else begin
                e = sb_q.pop_front();
                check("resp_err", 32'(bus.resp_err), 32'(e.err));
                check("resp_rdata", bus.resp_rdata, e.rdata);
                check("resp_cycle", cyc, e.cyc);
                check("req_ready_in_resp", 32'(bus.req_ready), 32'h0);
            end
        end
    end

    // Memory responder: checks the request fields every cycle they are
    // presented and acks on the chosen cycle of the request.
    always @(negedge clk) begin
        int lim;
        if (bus.mem_req === 1'b1) begin
            if (mcnt == 0) begin
                if (mq.size() == 0) begin
                    flag("unexpected_mem_req");
                    cur_valid = 0;
                end else begin
                    cur = mq.pop_front();
                    cur_valid = 1;
                end
            end
            mcnt++;
            if (cur_valid) begin
                lim = (cur.d < TO) ? cur.d : TO;
                check("mem_addr", 32'(bus.mem_addr), 32'(cur.addr));
                check("mem_be", 32'(bus.mem_be), 32'(cur.be));
                check("mem_we", 32'(bus.mem_we), 32'(cur.we));
                if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
                check("mem_req_length_ok", 32'(mcnt <= lim), 32'h1);
            end
            bus.mem_ack   = cur_valid && (mcnt == cur.d);
            bus.mem_rdata = bus.mem_ack ? cur.rdata : $urandom;
        end else begin
            mcnt          = 0;
            cur_valid     = 0;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
        end
    end

    initial begin
        bit drained;
        garbage();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'h1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_resp_err", 32'(bus.resp_err), 32'h0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_mem_be", 32'(bus.mem_be), 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        rst = 1'b0;
        idle(2);

        // Directed accesses with hand-derived expectations.
        issue(1, 3'd0, 32'h100, 32'hDEADBEEF, 32'h0, 2, 0, 32'h0, 4'b1111, 32'hDEADBEEF, 1);
        idle(3);
        issue(0, 3'd3, 32'h103, 32'h0, 32'h80FFFF7F, 1, 0, 32'hFFFFFF80, 4'b1000, 32'h0, 1);
        idle(3);
        issue(0, 3'd4, 32'h103, 32'h0, 32'h80FFFF7F, 3, 0, 32'h00000080, 4'b1000, 32'h0, 1);
        idle(3);
        issue(1, 3'd1, 32'h102, 32'h0000ABCD, 32'h0, 1, 0, 32'h0, 4'b1100, 32'hABCDABCD, 1);
        idle(3);
        issue(0, 3'd1, 32'h102, 32'h0, 32'h7FFF0000, 2, 0, 32'h00007FFF, 4'b1100, 32'h0, 1);
        idle(3);
        issue(0, 3'd0, 32'h101, 32'h0, 32'h0, 1, 1, 32'h0, 4'b0, 32'h0, 1);
        idle(2);
        issue(0, 3'd5, 32'h100, 32'h0, 32'h0, 1, 1, 32'h0, 4'b0, 32'h0, 1);
        idle(2);
        issue(1, 3'd2, 32'h100, 32'h1234, 32'h0, 1, 1, 32'h0, 4'b0, 32'h0, 1);
        idle(2);
        issue(1, 3'd4, 32'h101, 32'h12, 32'h0, 1, 1, 32'h0, 4'b0, 32'h0, 1);
        idle(2);
        issue(0, 3'd1, 32'h101, 32'h0, 32'h0, 1, 1, 32'h0, 4'b0, 32'h0, 1);
        idle(2);
        issue(0, 3'd0, 32'h200, 32'h0, 32'h12345678, TO + 1, 0, 32'h0, 4'b1111, 32'h0, 1);
        idle(3);
        issue(0, 3'd0, 32'h204, 32'h0, 32'hCAFEF00D, TO, 0, 32'hCAFEF00D, 4'b1111, 32'h0, 1);
        // Back-to-back: the second request is held until after RESP.
        issue(0, 3'd4, 32'h001, 32'h0, 32'h0000AB00, 1, 0, 32'h000000AB, 4'b0010, 32'h0, 1);
        issue(1, 3'd3, 32'h002, 32'h0000005A, 32'h0, 1, 0, 32'h0, 4'b0100, 32'h5A5A5A5A, 1);
        idle(4);

        // Reset while waiting for the memory: request dropped, no response.
        issue(0, 3'd0, 32'h300, 32'h0, 32'h0, TO + 1, 0, 32'h0, 4'b1111, 32'h0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_mid_req_ready", 32'(bus.req_ready), 32'h1);
        check("rst_mid_resp_valid", 32'(bus.resp_valid), 32'h0);
        idle(8);

        // Randomized traffic, with and without gaps between requests.
        for (int t = 0; t < 200; t++) begin
            issue_rand();
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
        end

        drained = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && mq.size() == 0 && !bus.mem_req) begin
                drained = 1;
                break;
            end
        end
        if (!drained) flag("drain_expired_pending_expectations");
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
